// File: rtl/key4_debounce.sv
// key4_debounce: four-channel push-button conditioner.
// Each raw active-low key is synchronised, debounced to a clean active-high
// level, and turned into press/release pulses plus hold-to-repeat pulses.
// key_code/key_any summarise the debounced levels one cycle later.
module key4_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 25_000_000,
  parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_repeat,
  output logic [1:0] key_code,
  output logic       key_any
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE      = DW'(1);
  localparam logic [RW-1:0] RPT_ONE     = RW'(1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Synchroniser flops (hold raw active-low polarity, reset to released)
  logic [3:0]    sync1_q;
  logic [3:0]    sync2_q;
  logic [3:0]    sync_s;

  // Debounce state
  logic [DW-1:0] db_cnt_q [4];
  logic [DW-1:0] db_cnt_d [4];
  logic [3:0]    key_state_q, key_state_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;

  // Repeat state machines
  rpt_state_e    rpt_st_q [4];
  rpt_state_e    rpt_st_d [4];
  logic [RW-1:0] rpt_cnt_q [4];
  logic [RW-1:0] rpt_cnt_d [4];
  logic [3:0]    repeat_q, repeat_d;

  // Summary outputs
  logic [1:0]    code_q, code_d;
  logic          any_q, any_d;

  assign sync_s = ~sync2_q;

  // Debounce: count consecutive mismatches, accept the new level on the terminal count
  always_comb begin
    db_cnt_d    = db_cnt_q;
    key_state_d = key_state_q;
    press_d     = 4'b0000;
    release_d   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (sync_s[i] == key_state_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]    = '0;
        key_state_d[i] = sync_s[i];
        press_d[i]     = sync_s[i];
        release_d[i]   = ~sync_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  // Repeat FSM next state: driven by the level being registered this edge so a release wins
  always_comb begin
    rpt_st_d  = rpt_st_q;
    rpt_cnt_d = rpt_cnt_q;
    repeat_d  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (!key_state_d[i]) begin
        rpt_st_d[i]  = RPT_IDLE;
        rpt_cnt_d[i] = '0;
      end else begin
        case (rpt_st_q[i])
          RPT_IDLE: begin
            rpt_cnt_d[i] = '0;
            if (press_d[i]) begin
              rpt_st_d[i] = RPT_HOLD;
            end else begin
              rpt_st_d[i] = RPT_IDLE;
            end
          end
          RPT_HOLD: begin
            if (rpt_cnt_q[i] == HOLD_LAST) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
              rpt_st_d[i]  = RPT_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
            end
          end
          RPT_REPEAT: begin
            if (rpt_cnt_q[i] == REPEAT_LAST) begin
              repeat_d[i]  = 1'b1;
              rpt_cnt_d[i] = '0;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
            end
          end
          default: begin
            rpt_st_d[i]  = RPT_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Summary: lowest-numbered pressed key wins, computed from the registered level
  always_comb begin
    any_d = |key_state_q;
    casez (key_state_q)
      4'b???1: code_d = 2'd0;
      4'b??10: code_d = 2'd1;
      4'b?100: code_d = 2'd2;
      4'b1000: code_d = 2'd3;
      default: code_d = 2'd0;
    endcase
  end

  // State registers for synchroniser, debounce, repeat FSMs and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      key_state_q <= 4'b0000;
      press_q     <= 4'b0000;
      release_q   <= 4'b0000;
      repeat_q    <= 4'b0000;
      code_q      <= 2'd0;
      any_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
        rpt_st_q[i]  <= RPT_IDLE;
      end
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      code_q      <= code_d;
      any_q       <= any_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        rpt_st_q[i]  <= rpt_st_d[i];
      end
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;
  assign key_code    = code_q;
  assign key_any     = any_q;

endmodule

// File: tb/tb_key4_debounce.sv
// Directed bench for key4_debounce with short debounce/hold/repeat periods.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key4_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_repeat;
  logic [1:0] key_code;
  logic       key_any;

  int n_cmp = 0;
  int n_err = 0;

  key4_debounce #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_repeat(key_repeat),
    .key_code(key_code),
    .key_any(key_any)
  );

  // Clock: rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed sequence
  initial begin
    logic [3:0] exp_v;

    rst   = 1'b0;
    key_n = 4'b1111;

    // Reset state
    cyc(2);
    chk("rst_state",   key_state,   4'b0000);
    chk("rst_press",   key_press,   4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_repeat",  key_repeat,  4'b0000);
    chk("rst_code",    {2'b00, key_code}, 4'b0000);
    chk("rst_any",     {3'b000, key_any}, 4'b0000);
    rst = 1'b1;
    cyc(2);
    chk("idle_state", key_state, 4'b0000);

    // Clean press of key 0: accepted after edge 6
    key_n = 4'b1110;
    cyc(5);
    chk("t1_state_e5", key_state, 4'b0000);
    chk("t1_press_e5", key_press, 4'b0000);
    cyc(1);
    chk("t1_state_e6", key_state, 4'b0001);
    chk("t1_press_e6", key_press, 4'b0001);
    chk("t1_any_e6",   {3'b000, key_any}, 4'b0000);
    cyc(1);
    chk("t1_press_e7", key_press, 4'b0000);
    chk("t1_any_e7",   {3'b000, key_any}, 4'b0001);
    chk("t1_code_e7",  {2'b00, key_code}, 4'b0000);
    key_n = 4'b1111;
    cyc(5);
    chk("t1_rel_state_e5", key_state,   4'b0001);
    chk("t1_rel_e5",       key_release, 4'b0000);
    cyc(1);
    chk("t1_rel_state_e6", key_state,   4'b0000);
    chk("t1_rel_e6",       key_release, 4'b0001);
    chk("t1_rel_rep_e6",   key_repeat,  4'b0000);
    cyc(1);
    chk("t1_rel_e7",     key_release, 4'b0000);
    chk("t1_rel_any_e7", {3'b000, key_any}, 4'b0000);

    // Bounce on key 2: 3-cycle segments never reach the debounce count
    for (int seg = 0; seg < 10; seg++) begin
      key_n = (seg % 2 == 0) ? 4'b1011 : 4'b1111;
      for (int c = 0; c < 3; c++) begin
        cyc(1);
        chk("t2_bounce_state", key_state, 4'b0000);
        chk("t2_bounce_press", key_press, 4'b0000);
      end
    end
    key_n = 4'b1011;
    cyc(5);
    chk("t2_state_e5", key_state, 4'b0000);
    cyc(1);
    chk("t2_state_e6", key_state, 4'b0100);
    chk("t2_press_e6", key_press, 4'b0100);
    cyc(1);
    chk("t2_press_e7", key_press, 4'b0000);
    chk("t2_code_e7",  {2'b00, key_code}, 4'b0010);
    chk("t2_any_e7",   {3'b000, key_any}, 4'b0001);
    key_n = 4'b1111;
    cyc(6);
    chk("t2_release", key_release, 4'b0100);
    chk("t2_rel_rep", key_repeat,  4'b0000);
    cyc(1);
    chk("t2_any_off", {3'b000, key_any}, 4'b0000);

    // Hold-repeat on key 1: repeats at +10, +15 ... +35, release accepted at +39
    key_n = 4'b1101;
    cyc(6);
    chk("t3_press", key_press, 4'b0010);
    chk("t3_state", key_state, 4'b0010);
    for (int k = 1; k <= 45; k++) begin
      cyc(1);
      exp_v = (k >= 10 && k <= 35 && ((k - 10) % 5) == 0) ? 4'b0010 : 4'b0000;
      chk("t3_repeat", key_repeat, exp_v);
      exp_v = (k == 39) ? 4'b0010 : 4'b0000;
      chk("t3_release", key_release, exp_v);
      exp_v = (k < 39) ? 4'b0010 : 4'b0000;
      chk("t3_state", key_state, exp_v);
      chk("t3_press_quiet", key_press, 4'b0000);
      if (k == 33) begin
        key_n = 4'b1111;
      end
    end

    // Key 3 released exactly when the repeat counter is terminal
    key_n = 4'b0111;
    cyc(6);
    chk("t4_press", key_press, 4'b1000);
    cyc(9);
    chk("t4_rep_p9", key_repeat, 4'b0000);
    key_n = 4'b1111;
    cyc(1);
    chk("t4_rep_p10",   key_repeat, 4'b1000);
    chk("t4_state_p10", key_state,  4'b1000);
    cyc(4);
    chk("t4_rep_p14", key_repeat,  4'b0000);
    chk("t4_rel_p14", key_release, 4'b0000);
    cyc(1);
    chk("t4_rel_p15",   key_release, 4'b1000);
    chk("t4_rep_p15",   key_repeat,  4'b0000);
    chk("t4_state_p15", key_state,   4'b0000);
    cyc(1);
    chk("t4_rep_p16", key_repeat, 4'b0000);
    chk("t4_any_p16", {3'b000, key_any}, 4'b0000);

    // Simultaneous keys 3 and 1
    key_n = 4'b0101;
    cyc(6);
    chk("t5_press", key_press, 4'b1010);
    chk("t5_state", key_state, 4'b1010);
    cyc(1);
    chk("t5_code_13", {2'b00, key_code}, 4'b0001);
    chk("t5_any",     {3'b000, key_any}, 4'b0001);
    key_n = 4'b0111;
    cyc(6);
    chk("t5_rel1",       key_release, 4'b0010);
    chk("t5_state_rel1", key_state,   4'b1000);
    cyc(1);
    chk("t5_code_3", {2'b00, key_code}, 4'b0011);
    key_n = 4'b1110;
    cyc(2);
    chk("t5_rep3", key_repeat, 4'b1000);
    cyc(4);
    chk("t5_press0", key_press,   4'b0001);
    chk("t5_rel3",   key_release, 4'b1000);
    chk("t5_state",  key_state,   4'b0001);
    chk("t5_norep",  key_repeat,  4'b0000);

    // Key 0 into REPEAT, then asynchronous reset mid-count
    cyc(10);
    chk("t6_rep_q10", key_repeat, 4'b0001);
    cyc(2);
    chk("t6_state_q12", key_state, 4'b0001);
    chk("t6_any_q12",   {3'b000, key_any}, 4'b0001);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_state",   key_state,   4'b0000);
    chk("t6_rst_press",   key_press,   4'b0000);
    chk("t6_rst_release", key_release, 4'b0000);
    chk("t6_rst_repeat",  key_repeat,  4'b0000);
    chk("t6_rst_code",    {2'b00, key_code}, 4'b0000);
    chk("t6_rst_any",     {3'b000, key_any}, 4'b0000);
    cyc(2);
    chk("t6_rst_hold_state", key_state, 4'b0000);
    rst = 1'b1;
    cyc(5);
    chk("t6_state_e5", key_state, 4'b0000);
    chk("t6_press_e5", key_press, 4'b0000);
    cyc(1);
    chk("t6_press_e6", key_press, 4'b0001);
    chk("t6_state_e6", key_state, 4'b0001);
    cyc(9);
    chk("t6_rep_r9", key_repeat, 4'b0000);
    cyc(1);
    chk("t6_rep_r10", key_repeat, 4'b0001);
    key_n = 4'b1111;
    cyc(5);
    chk("t6_rep_r15", key_repeat,  4'b0001);
    chk("t6_rel_r15", key_release, 4'b0000);
    cyc(1);
    chk("t6_rel_r16",   key_release, 4'b0001);
    chk("t6_rep_r16",   key_repeat,  4'b0000);
    chk("t6_state_r16", key_state,   4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key4_debounce.md
# key4_debounce

Four-channel push-button input conditioner for the LED demo boards: the input side that pairs with the LED pattern drivers. It synchronises raw active-low key pins, debounces each key independently and produces a clean level, one-cycle press/release pulses and hold-to-repeat pulses. The LED controllers use these pulses to step, pause or restart their pattern sequences.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a level change (≥2).
- `HOLD_CYCLES`, default 25_000_000: cycles a key must stay debounced-pressed before the first repeat pulse (≥2).
- `REPEAT_CYCLES`, default 5_000_000: period of subsequent repeat pulses while held (≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key_n`  in  4  raw key pins, active-low (0 = pressed), asynchronous to `clk`.
- `key_state`  out  4  debounced level, active-high (1 = pressed).
- `key_press`  out  4  one-cycle pulse per key on accepted 0→1 of `key_state`.
- `key_release`  out  4  one-cycle pulse per key on accepted 1→0 of `key_state`.
- `key_repeat`  out  4  one-cycle pulse per key while held (see Operation).
- `key_code`  out  2  index of lowest-numbered key with `key_state` = 1; 0 when none.
- `key_any`  out  1  OR of `key_state`.

## Operation
- Per key: 2-flop synchroniser on `key_n[i]`, inverted to active-high `sync[i]`.
- Debounce counter per key, width clog2(DEBOUNCE_CYCLES): cleared in any cycle where `sync[i]` == `key_state[i]`; otherwise increments. When counter == DEBOUNCE_CYCLES-1 and `sync[i]` still differs, `key_state[i]` toggles and counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles (at synchroniser output) never changes `key_state`; a single mismatching-back cycle restarts the count from 0.
- `key_press[i]`/`key_release[i]` asserted in the same cycle `key_state[i]` is registered with its new value; exactly one cycle wide.
- Repeat state machine per key, states IDLE, HOLD, REPEAT:
  - IDLE: on press → HOLD, hold counter = 0.
  - HOLD: counter increments each cycle; when counter == HOLD_CYCLES-1 → pulse `key_repeat[i]`, counter = 0, go REPEAT.
  - REPEAT: counter increments; when counter == REPEAT_CYCLES-1 → pulse `key_repeat[i]`, counter = 0, stay.
  - Any state: `key_state[i]` = 0 → IDLE, counter = 0, no repeat pulse that cycle (release has priority).
- `key_code`/`key_any` registered from the current `key_state`, one cycle behind it; priority key 0 highest.
- Keys fully independent; simultaneous events on several keys produce simultaneous pulses.

## Timing
- Reset (rst = 0, any time, including mid-count): synchroniser flops = 1 (released), `key_state` = 0, all pulses = 0, `key_code` = 0, `key_any` = 0, all counters = 0, all FSMs IDLE. Takes effect without a clock edge.
- Reset release with a key held: key is accepted as a normal press after debounce, producing `key_press`.
- Latency: raw edge stable from before edge E1 → `key_state` and `key_press` change after edge E(DEBOUNCE_CYCLES+2).
- First `key_repeat` HOLD_CYCLES cycles after `key_press`; then every REPEAT_CYCLES cycles.
- `key_code`/`key_any` lag `key_state` by exactly one cycle.
- Counters saturate never; they wrap only by the explicit clear rules above.

## Test plan
- Clean press (DEBOUNCE_CYCLES=4): drive `key_n`=4'b1110 steadily → `key_state`=4'b0001 and single `key_press`=4'b0001 after edge 6; `key_code`=0, `key_any`=1 one cycle later.
- Bounce: toggle `key_n[2]` every 3 cycles for 30 cycles, then hold 0 → no `key_state` change during bounce; one `key_press[2]` 6 edges after final settle.
- Hold-repeat (HOLD=10, REPEAT=5): hold key 1 for 40 cycles after press → `key_repeat[1]` pulses at +10, +15, +20, +25, +30, +35 cycles; release → one `key_release[1]`, no further repeats.
- Release on repeat boundary: release accepted in the cycle the repeat counter reaches its terminal value → `key_release` = 1, `key_repeat` = 0 that cycle.
- Simultaneous keys: press keys 3 and 1 together → `key_press`=4'b1010 in one cycle, `key_code`=1; release key 1 → `key_code`=3.
- Mid-operation reset: assert rst while key 0 held in REPEAT → all outputs 0 immediately; deassert with key still held → new `key_press[0]` after debounce.
